mac_frame_acc: RTL and testbench

Downstream consumer of the multiply-add stage (d = a·b + c, 16-bit result). Accepts one 16-bit result per valid/ready handshake, accumulates FRAME_LEN consecutive samples into a wider running sum, and presents the frame total on a registered valid/ready output. Turns the per-sample datapath into a frame-sum stream for the next consumer.

---
 rtl/mac_frame_acc_if.sv | 39 +++
 rtl/mac_frame_acc.sv | 109 ++++++++++
 tb/tb_mac_frame_acc.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_frame_acc_if.sv
// mac_frame_acc_if
// Purpose: groups the sample-input and frame-sum-output handshakes of
//          mac_frame_acc into one bundle.
// Signals:
//   d_i          sample (unsigned, IN_W bits)
//   d_valid_i    sample valid
//   d_ready_o    accumulator can take a sample this cycle
//   sum_o        frame sum (unsigned, ACC_W bits)
//   sum_valid_o  sum_o / overflow_o valid
//   sum_ready_i  downstream accepts sum_o
//   overflow_o   frame sum exceeded 2^ACC_W-1
//   count_o      samples accepted in the current frame
// Modports: master = producer/consumer side, slave = accumulator side.
interface mac_frame_acc_if #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 4
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic [IN_W-1:0]  d_i;
  logic             d_valid_i;
  logic             d_ready_o;
  logic [ACC_W-1:0] sum_o;
  logic             sum_valid_o;
  logic             sum_ready_i;
  logic             overflow_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output d_i, d_valid_i, sum_ready_i,
    input  d_ready_o, sum_o, sum_valid_o, overflow_o, count_o
  );

  modport slave (
    input  d_i, d_valid_i, sum_ready_i,
    output d_ready_o, sum_o, sum_valid_o, overflow_o, count_o
  );
endinterface

// File: rtl/mac_frame_acc.sv
// mac_frame_acc
// Purpose: accumulates FRAME_LEN consecutive multiply-add results into a
//          wider running sum and presents each frame total on a registered
//          valid/ready output. One bubble cycle per frame while the total
//          is held.
// Ports:
//   clk_i   single clock, all state on rising edge
//   rst_i   synchronous active-high reset
//   bus     mac_frame_acc_if.slave (sample in, frame sum out, count)
// Parameters: IN_W (sample width), ACC_W (sum width, IN_W..32),
//             FRAME_LEN (samples per frame, 1..255); must match the
//             parameters of the connected interface.
// Build option: define MAC_FRAME_ACC_SAT_EN to clamp the frame sum to
//               all-ones on overflow; otherwise the sum wraps modulo
//               2^ACC_W. overflow_o behaves the same in both builds.
module mac_frame_acc #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  mac_frame_acc_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int NXT_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_sticky;
  logic [ACC_W-1:0] r_sum;
  logic             r_ovf;

  logic [NXT_W-1:0] w_next;
  logic             w_carry;
  logic             w_ovf;
  logic [ACC_W-1:0] w_accNext;

  // One extra bit catches the carry out of the accumulator; the sticky
  // flag remembers any earlier carry within the same frame.
  assign w_next  = {1'b0, r_acc} + NXT_W'(bus.d_i);
  assign w_carry = w_next[ACC_W];
  assign w_ovf   = r_sticky | w_carry;

`ifdef MAC_FRAME_ACC_SAT_EN
  // Once a frame has overflowed the accumulator stays pinned at all-ones.
  assign w_accNext = w_ovf ? {ACC_W{1'b1}} : w_next[ACC_W-1:0];
`else
  assign w_accNext = w_next[ACC_W-1:0];
`endif

  // Outputs decode registered state only, so nothing on the input side
  // reaches an output combinationally.
  assign bus.d_ready_o   = (r_state == ACCUM);
  assign bus.sum_valid_o = (r_state == HOLD);
  assign bus.sum_o       = r_sum;
  assign bus.overflow_o  = r_ovf;
  assign bus.count_o     = r_count;

  // Frame FSM: ACCUM takes samples until the last one of the frame, which
  // is folded straight into sum_o; HOLD parks the total until downstream
  // takes it. The accumulator is cleared on the final sample so the next
  // frame starts from zero as soon as HOLD is left.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ACCUM;
      r_acc    <= '0;
      r_count  <= '0;
      r_sticky <= 1'b0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (bus.d_valid_i) begin
            if (r_count == LAST_IDX) begin
              r_sum    <= w_accNext;
              r_ovf    <= w_ovf;
              r_state  <= HOLD;
              r_acc    <= '0;
              r_count  <= '0;
              r_sticky <= 1'b0;
            end else begin
              r_acc    <= w_accNext;
              r_count  <= r_count + 1'b1;
              r_sticky <= w_ovf;
            end
          end
        end
        HOLD: begin
          if (bus.sum_ready_i) begin
            r_state <= ACCUM;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_frame_acc.sv
// tb_mac_frame_acc
// Purpose: self-checking bench for mac_frame_acc. Three instances cover
//          the default configuration, a narrow 17-bit accumulator and
//          single-sample frames. A frame-level reference model predicts
//          every output after every clock edge.
// Build option: MAC_FRAME_ACC_SAT_EN selects the saturating expectation.
module tb_mac_frame_acc;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference model state, one entry per instance (0=A, 1=B, 2=C).
  longint unsigned mSum[3];
  longint unsigned mSumOut[3];
  int              mCnt[3];
  bit              mHold[3];
  bit              mOvfOut[3];

  mac_frame_acc_if #(.IN_W(16), .ACC_W(24), .FRAME_LEN(4)) ifA ();
  mac_frame_acc_if #(.IN_W(16), .ACC_W(17), .FRAME_LEN(4)) ifB ();
  mac_frame_acc_if #(.IN_W(16), .ACC_W(24), .FRAME_LEN(1)) ifC ();

  mac_frame_acc #(.IN_W(16), .ACC_W(24), .FRAME_LEN(4)) dutA (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifA.slave)
  );

  mac_frame_acc #(.IN_W(16), .ACC_W(17), .FRAME_LEN(4)) dutB (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifB.slave)
  );

  mac_frame_acc #(.IN_W(16), .ACC_W(24), .FRAME_LEN(1)) dutC (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifC.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frameLen(input int id);
    return (id == 2) ? 1 : 4;
  endfunction

  function automatic longint unsigned accMax(input int id);
    int w;
    w = (id == 1) ? 17 : 24;
    return (64'd1 << w) - 64'd1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame-level prediction: a frame's total is the plain sum of its
  // samples; it overflows exactly when that total exceeds the accumulator
  // range.
  task automatic modelStep(input int id, input int d, input bit v, input bit r);
    longint unsigned total;
    bit              ovf;
    if (mHold[id]) begin
      if (r) begin
        mHold[id]   = 1'b0;
        mOvfOut[id] = 1'b0;
      end
    end else if (v) begin
      total = mSum[id] + longint'(d);
      mCnt[id]++;
      if (mCnt[id] == frameLen(id)) begin
        ovf = (total > accMax(id));
`ifdef MAC_FRAME_ACC_SAT_EN
        mSumOut[id] = ovf ? accMax(id) : total;
`else
        mSumOut[id] = total & accMax(id);
`endif
        mOvfOut[id] = ovf;
        mHold[id]   = 1'b1;
        mSum[id]    = 0;
        mCnt[id]    = 0;
      end else begin
        mSum[id] = total;
      end
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mSum[i]    = 0;
      mSumOut[i] = 0;
      mCnt[i]    = 0;
      mHold[i]   = 1'b0;
      mOvfOut[i] = 1'b0;
    end
  endtask

  task automatic checkOutput(input int id);
    logic [63:0] oReady, oValid, oSum, oOvf, oCnt;
    case (id)
      0: begin
        oReady = 64'(ifA.d_ready_o); oValid = 64'(ifA.sum_valid_o);
        oSum = 64'(ifA.sum_o); oOvf = 64'(ifA.overflow_o); oCnt = 64'(ifA.count_o);
      end
      1: begin
        oReady = 64'(ifB.d_ready_o); oValid = 64'(ifB.sum_valid_o);
        oSum = 64'(ifB.sum_o); oOvf = 64'(ifB.overflow_o); oCnt = 64'(ifB.count_o);
      end
      default: begin
        oReady = 64'(ifC.d_ready_o); oValid = 64'(ifC.sum_valid_o);
        oSum = 64'(ifC.sum_o); oOvf = 64'(ifC.overflow_o); oCnt = 64'(ifC.count_o);
      end
    endcase
    check($sformatf("d_ready[%0d]", id),   oReady, 64'(!mHold[id]));
    check($sformatf("sum_valid[%0d]", id), oValid, 64'(mHold[id]));
    check($sformatf("sum[%0d]", id),       oSum,   64'(mSumOut[id]));
    check($sformatf("overflow[%0d]", id),  oOvf,   64'(mOvfOut[id]));
    check($sformatf("count[%0d]", id),     oCnt,   64'(mCnt[id]));
  endtask

  // Drives one instance for one clock; the others sit idle so they hold.
  task automatic applyStimulus(input int id, input int d, input bit v, input bit r);
    ifA.d_i = '0; ifA.d_valid_i = 1'b0; ifA.sum_ready_i = 1'b0;
    ifB.d_i = '0; ifB.d_valid_i = 1'b0; ifB.sum_ready_i = 1'b0;
    ifC.d_i = '0; ifC.d_valid_i = 1'b0; ifC.sum_ready_i = 1'b0;
    case (id)
      0: begin ifA.d_i = 16'(d); ifA.d_valid_i = v; ifA.sum_ready_i = r; end
      1: begin ifB.d_i = 16'(d); ifB.d_valid_i = v; ifB.sum_ready_i = r; end
      default: begin ifC.d_i = 16'(d); ifC.d_valid_i = v; ifC.sum_ready_i = r; end
    endcase
    @(posedge clk);
    modelStep(id, d, v, r);
    #1;
    checkOutput(id);
  endtask

  // Reset while the selected instance has valid and ready asserted, so a
  // simultaneous handshake must lose to reset.
  task automatic applyReset(input int id);
    rst = 1'b1;
    case (id)
      0: begin ifA.d_i = 16'd77; ifA.d_valid_i = 1'b1; ifA.sum_ready_i = 1'b1; end
      1: begin ifB.d_i = 16'd77; ifB.d_valid_i = 1'b1; ifB.sum_ready_i = 1'b1; end
      default: begin ifC.d_i = 16'd77; ifC.d_valid_i = 1'b1; ifC.sum_ready_i = 1'b1; end
    endcase
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) checkOutput(i);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ifA.d_i = '0; ifA.d_valid_i = 1'b0; ifA.sum_ready_i = 1'b0;
    ifB.d_i = '0; ifB.d_valid_i = 1'b0; ifB.sum_ready_i = 1'b0;
    ifC.d_i = '0; ifC.d_valid_i = 1'b0; ifC.sum_ready_i = 1'b0;
    modelReset();
    $display("[TB] start");

    // Reset state of all instances.
    applyReset(0);
    applyReset(1);

    // Continuous frame 10,20,30,40 -> 100, one-cycle valid.
    applyStimulus(0, 10, 1'b1, 1'b1);
    applyStimulus(0, 20, 1'b1, 1'b1);
    applyStimulus(0, 30, 1'b1, 1'b1);
    applyStimulus(0, 40, 1'b1, 1'b1);
    applyStimulus(0, 50, 1'b1, 1'b1);
    applyStimulus(0, 0,  1'b0, 1'b1);

    // Gapped frame of 65280 x4 -> 261120, count steps 1,2,3 then 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 65280, 1'b1, 1'b1);
      applyStimulus(0, 0,     1'b0, 1'b1);
    end

    // 17-bit accumulator overflows, then a clean frame of ones.
    for (int i = 0; i < 4; i++) applyStimulus(1, 65280, 1'b1, 1'b0);
    applyStimulus(1, 0, 1'b0, 1'b0);
    applyStimulus(1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1'b1, 1'b0);
    applyStimulus(1, 0, 1'b0, 1'b1);

    // Backpressure with 99 offered while the total is held.
    for (int i = 1; i <= 4; i++) applyStimulus(0, i, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 99, 1'b1, 1'b0);
    applyStimulus(0, 99, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(0, i * 100, 1'b1, 1'b1);
    applyStimulus(0, 0, 1'b0, 1'b1);

    // Reset after two samples of a frame, then frame 1,2,3,4 -> 10.
    applyStimulus(0, 5, 1'b1, 1'b1);
    applyStimulus(0, 7, 1'b1, 1'b1);
    applyReset(0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, i, 1'b1, 1'b1);
    applyStimulus(0, 0, 1'b0, 1'b1);

    // Reset while a total is held.
    for (int i = 0; i < 4; i++) applyStimulus(1, 60000, 1'b1, 1'b0);
    applyReset(1);

    // Single-sample frames: 3 then 9 with one bubble between accepts.
    applyStimulus(2, 3, 1'b1, 1'b1);
    applyStimulus(2, 9, 1'b1, 1'b1);
    applyStimulus(2, 9, 1'b1, 1'b1);
    applyStimulus(2, 0, 1'b0, 1'b1);

    // Randomized traffic on every instance, mixing near-full-scale samples.
    for (int id = 0; id < 3; id++) begin
      for (int n = 0; n < 80; n++) begin
        int  d;
        bit  v;
        bit  r;
        d = ($urandom_range(0, 1) == 1) ? (65280 + int'($urandom_range(0, 255)))
                                         : int'($urandom_range(0, 65535));
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        applyStimulus(id, d, v, r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
